// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the three-requestor shared memory controller.
package mem_ctrl_pkg;

    localparam int NUM_REQ       = 3;
    localparam int NUM_PORTS     = 2;
    localparam int MC_DATA_WIDTH = 32;
    localparam int MC_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_ACL = 2'd1,
        REQ_DMA = 2'd2
    } req_id_e;

    typedef struct packed {
        logic                     valid;
        logic                     wr;
        logic [MC_ADDR_WIDTH-1:0] addr;
        logic [MC_DATA_WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/mc_dpram.sv
// Dual-port synchronous word RAM, write-first on both ports, registered read data.
// Simultaneous writes to one address store the port A data.
module mc_dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] a_rdata_d, a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_d, b_rdata_q;

    // A read sees its own write or the other port's same-cycle write to that address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        a_rdata_d = a_rdata_q;
        if (a_en) begin
            if (a_we)                               a_rdata_d = a_wdata;
            else if (b_en && b_we && b_addr == a_addr) a_rdata_d = b_wdata;
            else                                    a_rdata_d = mem[a_addr];
        end
    end

    always_comb begin
        b_rdata_d = b_rdata_q;
        if (b_en) begin
            if (b_we)                               b_rdata_d = b_wdata;
            else if (a_en && a_we && a_addr == b_addr) b_rdata_d = a_wdata;
            else                                    b_rdata_d = mem[b_addr];
        end
    end

    // NOTE: the array and its read registers carry no reset, so they map onto RAM macros.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment; port A is written last so it wins a collision.
        a_rdata_q <= a_rdata_d;
        b_rdata_q <= b_rdata_d;
        if (b_en && b_we) mem[b_addr] <= b_wdata;
        if (a_en && a_we) mem[a_addr] <= a_wdata;
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/shared_memory_controller.sv
// CPU / accelerator / DMA arbiter over a dual-port RAM: two grants per cycle,
// one-entry pending buffer per requestor, 1-cycle registered responses.
module shared_memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = MC_DATA_WIDTH,
    parameter int ADDR_WIDTH = MC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CPUEn,
    input  logic                  CPUWrEn,
    input  logic [ADDR_WIDTH-1:0] CPUAddr,
    input  logic [DATA_WIDTH-1:0] CPUData,
    output logic [DATA_WIDTH-1:0] CPUOut,
    output logic                  CPUValid,
    input  logic                  AclEn,
    input  logic                  AclWrEn,
    input  logic [ADDR_WIDTH-1:0] AclAddr,
    input  logic [DATA_WIDTH-1:0] AclData,
    output logic [DATA_WIDTH-1:0] AclOut,
    output logic                  AclValid,
    input  logic                  DMAEn,
    input  logic                  DMAWrEn,
    input  logic [ADDR_WIDTH-1:0] DMAAddr,
    input  logic [DATA_WIDTH-1:0] DMAData,
    output logic [DATA_WIDTH-1:0] DMAOut,
    output logic                  DMAValid
);

    req_t                  live     [NUM_REQ];
    req_t                  eff      [NUM_REQ];
    req_t                  pend_d   [NUM_REQ];
    req_t                  pend_q   [NUM_REQ];
    logic [NUM_REQ-1:0]    granted;
    logic [NUM_PORTS-1:0]  grant_vld;
    req_id_e               grant_id [NUM_PORTS];
    req_t                  port_req [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]  tag_vld_d, tag_vld_q;
    req_id_e               tag_id_d [NUM_PORTS];
    req_id_e               tag_id_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] hold_d   [NUM_REQ];
    logic [DATA_WIDTH-1:0] hold_q   [NUM_REQ];
    logic [DATA_WIDTH-1:0] rsp_data [NUM_REQ];
    logic [NUM_REQ-1:0]    rsp_vld;

    assign live[REQ_CPU] = '{valid: CPUEn, wr: CPUWrEn, addr: CPUAddr, data: CPUData};
    assign live[REQ_ACL] = '{valid: AclEn, wr: AclWrEn, addr: AclAddr, data: AclData};
    assign live[REQ_DMA] = '{valid: DMAEn, wr: DMAWrEn, addr: DMAAddr, data: DMAData};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) eff[i] = pend_q[i].valid ? pend_q[i] : live[i];
    end

    // Buffered entries rank first, then live requests in CPU > Acl > DMA order.
    always_comb begin
        grant_vld = '0;
        granted   = '0;
        grant_id  = '{default: REQ_CPU};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_q[i].valid) begin
                if (!grant_vld[0]) begin
                    grant_vld[0] = 1'b1; grant_id[0] = req_id_e'(i[1:0]); granted[i] = 1'b1;
                end else if (!grant_vld[1]) begin
                    grant_vld[1] = 1'b1; grant_id[1] = req_id_e'(i[1:0]); granted[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend_q[i].valid && live[i].valid) begin
                if (!grant_vld[0]) begin
                    grant_vld[0] = 1'b1; grant_id[0] = req_id_e'(i[1:0]); granted[i] = 1'b1;
                end else if (!grant_vld[1]) begin
                    grant_vld[1] = 1'b1; grant_id[1] = req_id_e'(i[1:0]); granted[i] = 1'b1;
                end
            end
        end
    end

    // A live request arriving while the buffer is occupied is dropped.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_d[i] = pend_q[i];
            if (pend_q[i].valid) begin
                if (granted[i]) pend_d[i].valid = 1'b0;
            end else if (live[i].valid && !granted[i]) begin
                pend_d[i] = live[i];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_req[p]       = eff[grant_id[p]];
            port_req[p].valid = grant_vld[p];
            tag_vld_d[p]      = grant_vld[p];
            tag_id_d[p]       = grant_id[p];
        end
    end

    mc_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .a_en    (port_req[0].valid),
        .a_we    (port_req[0].valid & port_req[0].wr),
        .a_addr  (port_req[0].addr),
        .a_wdata (port_req[0].data),
        .a_rdata (port_rdata[0]),
        .b_en    (port_req[1].valid),
        .b_we    (port_req[1].valid & port_req[1].wr),
        .b_addr  (port_req[1].addr),
        .b_wdata (port_req[1].data),
        .b_rdata (port_rdata[1])
    );

    // Registered grant tags steer each port's read data back to its requestor.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            logic hit_a, hit_b;
            hit_a       = tag_vld_q[0] && (tag_id_q[0] == req_id_e'(i[1:0]));
            hit_b       = tag_vld_q[1] && (tag_id_q[1] == req_id_e'(i[1:0]));
            rsp_vld[i]  = hit_a | hit_b;
            rsp_data[i] = hit_a ? port_rdata[0] : (hit_b ? port_rdata[1] : hold_q[i]);
            hold_d[i]   = rsp_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '{default: REQ_CPU};
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_q[i] <= pend_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign CPUOut   = rsp_data[REQ_CPU];
    assign AclOut   = rsp_data[REQ_ACL];
    assign DMAOut   = rsp_data[REQ_DMA];
    assign CPUValid = rsp_vld[REQ_CPU];
    assign AclValid = rsp_vld[REQ_ACL];
    assign DMAValid = rsp_vld[REQ_DMA];

endmodule

// File: tb/tb_shared_memory_controller.sv
// Directed self-checking bench for shared_memory_controller.
module tb_shared_memory_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CPUEn, CPUWrEn, AclEn, AclWrEn, DMAEn, DMAWrEn;
    logic [15:0] CPUAddr, AclAddr, DMAAddr;
    logic [31:0] CPUData, AclData, DMAData;
    logic [31:0] CPUOut, AclOut, DMAOut;
    logic        CPUValid, AclValid, DMAValid;

    logic [31:0] outs [3];
    logic        vlds [3];
    int          checks   = 0;
    int          failures = 0;

    assign outs[0] = CPUOut;   assign outs[1] = AclOut;   assign outs[2] = DMAOut;
    assign vlds[0] = CPUValid; assign vlds[1] = AclValid; assign vlds[2] = DMAValid;

    shared_memory_controller dut (
        .clk      (clk),      .rst_n    (rst_n),
        .CPUEn    (CPUEn),    .CPUWrEn  (CPUWrEn),  .CPUAddr (CPUAddr), .CPUData (CPUData),
        .CPUOut   (CPUOut),   .CPUValid (CPUValid),
        .AclEn    (AclEn),    .AclWrEn  (AclWrEn),  .AclAddr (AclAddr), .AclData (AclData),
        .AclOut   (AclOut),   .AclValid (AclValid),
        .DMAEn    (DMAEn),    .DMAWrEn  (DMAWrEn),  .DMAAddr (DMAAddr), .DMAData (DMAData),
        .DMAOut   (DMAOut),   .DMAValid (DMAValid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        CPUEn = 0; CPUWrEn = 0; CPUAddr = '0; CPUData = '0;
        AclEn = 0; AclWrEn = 0; AclAddr = '0; AclData = '0;
        DMAEn = 0; DMAWrEn = 0; DMAAddr = '0; DMAData = '0;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [15:0] a, input logic [31:0] d);
        case (r)
            0:       begin CPUEn = 1; CPUWrEn = wr; CPUAddr = a; CPUData = d; end
            1:       begin AclEn = 1; AclWrEn = wr; AclAddr = a; AclData = d; end
            default: begin DMAEn = 1; DMAWrEn = wr; DMAAddr = a; DMAData = d; end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_reqs();
        #12;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (vlds[j] !== 1'b0 || outs[j] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state req=%0d valid=%b out=%h expected valid=0 out=0", j, vlds[j], outs[j]);
            end
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({CPUValid, AclValid, DMAValid} !== 3'b000) begin
                failures++;
                $display("FAIL idle_after_reset cycle=%0d valids=%b expected 000", c, {CPUValid, AclValid, DMAValid});
            end
        end
    endtask

    task automatic test_single_writes();
        int          r;
        logic [15:0] a;
        logic [31:0] d;
        for (int k = 0; k < 100; k++) begin
            r = $urandom_range(0, 2);
            a = 16'($urandom);
            d = $urandom;
            clear_reqs();
            set_req(r, 1'b1, a, d);
            step();
            clear_reqs();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (vlds[j] !== (j == r)) begin
                    failures++;
                    $display("FAIL single_valid iter=%0d req=%0d valid=%b expected %b", k, j, vlds[j], (j == r));
                end
            end
            checks++;
            if (outs[r] !== d) begin
                failures++;
                $display("FAIL single_echo iter=%0d req=%0d out=%h expected %h", k, r, outs[r], d);
            end
        end
        step();
    endtask

    task automatic test_dual_writes();
        int          pa [3] = '{0, 0, 1};
        int          pb [3] = '{1, 2, 2};
        logic [15:0] a;
        logic [31:0] da, db;
        for (int k = 0; k < 3; k++) begin
            a  = 16'($urandom);
            da = $urandom;
            db = da ^ 32'h5A5A_0001;
            clear_reqs();
            set_req(pa[k], 1'b1, a, da);
            set_req(pb[k], 1'b1, a ^ 16'h0001, db);
            step();
            clear_reqs();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (vlds[j] !== (j == pa[k] || j == pb[k])) begin
                    failures++;
                    $display("FAIL dual_valid pair=%0d req=%0d valid=%b expected %b", k, j, vlds[j], (j == pa[k] || j == pb[k]));
                end
            end
            checks++;
            if (outs[pa[k]] !== da || outs[pb[k]] !== db) begin
                failures++;
                $display("FAIL dual_echo pair=%0d outs=%h/%h expected %h/%h", k, outs[pa[k]], outs[pb[k]], da, db);
            end
        end
        step();
    endtask

    task automatic test_triple_writes();
        clear_reqs();
        set_req(0, 1'b1, 16'h2000, 32'd1);
        set_req(1, 1'b1, 16'h4000, 32'd2);
        set_req(2, 1'b1, 16'h3000, 32'd3);
        step();
        clear_reqs();
        checks++;
        if ({CPUValid, AclValid, DMAValid} !== 3'b110 || CPUOut !== 32'd1 || AclOut !== 32'd2) begin
            failures++;
            $display("FAIL triple_first valids=%b cpu=%h acl=%h expected 110 1 2", {CPUValid, AclValid, DMAValid}, CPUOut, AclOut);
        end
        step();
        checks++;
        if ({CPUValid, AclValid, DMAValid} !== 3'b001 || DMAOut !== 32'd3) begin
            failures++;
            $display("FAIL triple_second valids=%b dma=%h expected 001 3", {CPUValid, AclValid, DMAValid}, DMAOut);
        end
        step();
    endtask

    task automatic test_read_back();
        clear_reqs();
        set_req(0, 1'b0, 16'h3000, 32'hDEAD_BEEF);
        set_req(1, 1'b0, 16'h2000, 32'hDEAD_BEEF);
        step();
        clear_reqs();
        checks++;
        if (!CPUValid || !AclValid || CPUOut !== 32'd3 || AclOut !== 32'd1) begin
            failures++;
            $display("FAIL read_back cpu=%h acl=%h expected 3 1", CPUOut, AclOut);
        end
        // Port A writes, port B reads the same address.
        set_req(0, 1'b1, 16'h5000, 32'h0000_AAAA);
        set_req(1, 1'b0, 16'h5000, 32'h0);
        step();
        clear_reqs();
        checks++;
        if (CPUOut !== 32'h0000_AAAA || AclOut !== 32'h0000_AAAA || !AclValid) begin
            failures++;
            $display("FAIL raw_port_b cpu=%h acl=%h expected aaaa aaaa", CPUOut, AclOut);
        end
        // Port A reads, port B writes the same address.
        set_req(0, 1'b0, 16'h5100, 32'h0);
        set_req(1, 1'b1, 16'h5100, 32'h0000_BBBB);
        step();
        clear_reqs();
        checks++;
        if (CPUOut !== 32'h0000_BBBB || AclOut !== 32'h0000_BBBB || !CPUValid) begin
            failures++;
            $display("FAIL raw_port_a cpu=%h acl=%h expected bbbb bbbb", CPUOut, AclOut);
        end
        // Both ports write one address: each echoes its own, port A data is stored.
        set_req(0, 1'b1, 16'h6000, 32'h11);
        set_req(2, 1'b1, 16'h6000, 32'h22);
        step();
        clear_reqs();
        checks++;
        if (CPUOut !== 32'h11 || DMAOut !== 32'h22) begin
            failures++;
            $display("FAIL waw_echo cpu=%h dma=%h expected 11 22", CPUOut, DMAOut);
        end
        set_req(1, 1'b0, 16'h6000, 32'h0);
        step();
        clear_reqs();
        checks++;
        if (AclOut !== 32'h11 || !AclValid) begin
            failures++;
            $display("FAIL waw_stored acl=%h valid=%b expected 11 1", AclOut, AclValid);
        end
    endtask

    task automatic test_back_to_back();
        clear_reqs();
        set_req(0, 1'b1, 16'h9000, 32'hB0);
        for (int k = 0; k < 3; k++) begin
            step();
            clear_reqs();
            if (k < 2) set_req(0, 1'b1, 16'h9001 + 16'(k), 32'hB1 + 32'(k));
            checks++;
            if (!CPUValid || CPUOut !== 32'hB0 + 32'(k)) begin
                failures++;
                $display("FAIL b2b k=%0d valid=%b out=%h expected 1 %h", k, CPUValid, CPUOut, 32'hB0 + 32'(k));
            end
        end
        step();
        checks++;
        if (CPUValid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end valid=%b expected 0", CPUValid);
        end
    endtask

    task automatic test_pending_drop();
        int dma_valids = 0;
        clear_reqs();
        set_req(0, 1'b1, 16'h7100, 32'h10);
        set_req(1, 1'b1, 16'h7200, 32'h20);
        set_req(2, 1'b1, 16'h7000, 32'h77);
        step();
        clear_reqs();
        set_req(2, 1'b1, 16'h7000, 32'h99);
        dma_valids += int'(DMAValid);
        step();
        clear_reqs();
        dma_valids += int'(DMAValid);
        checks++;
        if (!DMAValid || DMAOut !== 32'h77) begin
            failures++;
            $display("FAIL pend_served valid=%b out=%h expected 1 77", DMAValid, DMAOut);
        end
        step();
        dma_valids += int'(DMAValid);
        step();
        dma_valids += int'(DMAValid);
        checks++;
        if (dma_valids != 1) begin
            failures++;
            $display("FAIL pend_drop_count dma_valids=%0d expected 1", dma_valids);
        end
        set_req(2, 1'b0, 16'h7000, 32'h0);
        step();
        clear_reqs();
        checks++;
        if (DMAOut !== 32'h77) begin
            failures++;
            $display("FAIL pend_dropped_write mem=%h expected 77", DMAOut);
        end
        step();
        step();
        checks++;
        if (DMAValid !== 1'b0 || DMAOut !== 32'h77 || CPUOut !== 32'h10) begin
            failures++;
            $display("FAIL out_hold valid=%b dma=%h cpu=%h expected 0 77 10", DMAValid, DMAOut, CPUOut);
        end
    endtask

    task automatic test_reset_mid();
        clear_reqs();
        set_req(0, 1'b1, 16'h8000, 32'hC1);
        set_req(1, 1'b1, 16'h8001, 32'hA1);
        set_req(2, 1'b1, 16'h8002, 32'hD1);
        step();
        clear_reqs();
        rst_n = 0;
        #1;
        checks++;
        if ({CPUValid, AclValid, DMAValid} !== 3'b000 || CPUOut !== 0 || AclOut !== 0 || DMAOut !== 0) begin
            failures++;
            $display("FAIL mid_reset valids=%b outs=%h/%h/%h expected 000 0/0/0", {CPUValid, AclValid, DMAValid}, CPUOut, AclOut, DMAOut);
        end
        @(negedge clk);
        rst_n = 1;
        step();
        checks++;
        if ({CPUValid, AclValid, DMAValid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_discard valids=%b expected 000", {CPUValid, AclValid, DMAValid});
        end
        set_req(0, 1'b0, 16'h8000, 32'h0);
        set_req(1, 1'b0, 16'h8001, 32'h0);
        step();
        clear_reqs();
        checks++;
        if (CPUOut !== 32'hC1 || AclOut !== 32'hA1) begin
            failures++;
            $display("FAIL mid_reset_committed cpu=%h acl=%h expected c1 a1", CPUOut, AclOut);
        end
    endtask

    initial begin
        test_reset();
        test_single_writes();
        test_dual_writes();
        test_triple_writes();
        test_read_back();
        test_back_to_back();
        test_pending_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_memory_controller.md
# shared_memory_controller

Three-requestor arbiter in front of a dual-port word RAM. It connects the CPU, the accelerator (Acl) and the DMA engine to one shared memory. Up to two requests are served per cycle. A request that loses arbitration is held in a one-entry per-requestor buffer and served in a later cycle.

## Interface
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 16: word address width; memory depth is 2^ADDR_WIDTH words.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- CPUEn / AclEn / DMAEn  in  1 each: request strobe, one request per cycle while high.
- CPUWrEn / AclWrEn / DMAWrEn  in  1 each: 1 = write, 0 = read; qualified by En.
- CPUAddr / AclAddr / DMAAddr  in  ADDR_WIDTH each: word address.
- CPUData / AclData / DMAData  in  DATA_WIDTH each: write data.
- CPUOut / AclOut / DMAOut  out  DATA_WIDTH each: response data, registered.
- CPUValid / AclValid / DMAValid  out  1 each: one-cycle pulse marking a response on the matching Out.

## Operation
- **Effective request per requestor:** the pending-buffer entry if one is held; otherwise the live input when En=1.
- **Live input while pending:** if a requestor's buffer is occupied, its live En is ignored and that request is dropped. A requestor must wait for its Valid before issuing again.
- **Arbitration:** rank effective requests as buffered entries first, then fixed priority CPU > Acl > DMA. The top two are granted: rank 1 → RAM port A, rank 2 → RAM port B.
- **Buffering:** an ungranted live request (at most one per cycle) is captured as addr, data and wr into that requestor's buffer. The buffer clears when the entry is granted.
- **Write:** mem[addr] <= data. The response Out = written data (write-through echo) with Valid=1.
- **Read:** Out = mem[addr] with Valid=1.
- **Same-cycle read and write to one address:** write-first; the read returns the new data.
- **Same-cycle writes from both ports to one address:** the port A (higher-ranked) data is stored and both requestors get their own data echoed.
- **Out hold:** each Out keeps its last value when its Valid is 0.
- **Reset:** all Out = 0, all Valid = 0, all buffers empty. Memory contents are not reset (undefined until written).

## Timing
- **Latency:** 1 cycle. A request sampled at rising edge N produces Out/Valid visible after edge N, stable for the cycle N..N+1.
- **Buffered request:** its response appears one cycle after the cycle in which it is granted. With three simultaneous requests and nothing buffered, DMA responds one cycle after CPU and Acl.
- **Valid:** high for exactly one cycle per served request. Back-to-back requests from one requestor give back-to-back Valids if each is granted.
- **Reset mid-operation:** asserting rst_n=0 immediately clears Valids, Outs and buffers. In-flight and buffered requests are discarded; a write already committed to the RAM stays.
- **Throughput:** at most 2 grants per cycle. A buffered entry always gets a port in the next cycle, because at most one buffer can be occupied at a time.

## Structure
- **Package `mem_ctrl_pkg`:**
  - requestor enum {REQ_CPU, REQ_ACL, REQ_DMA};
  - request struct {valid, wr, addr, data};
  - NUM_REQ = 3;
  - NUM_PORTS = 2.
- **Sub-module `mc_dpram`:**
  - two read/write ports;
  - synchronous, write-first, registered read data;
  - parameterised by DATA_WIDTH / ADDR_WIDTH.
- **Top level:**
  - arbiter (combinational ranking);
  - three buffer registers;
  - grant-to-port mux;
  - response demux to Out/Valid using registered grant tags.

## Test plan
- **Reset:** hold rst_n=0 → all Out=0, all Valid=0. Release, with no En asserted → Valids stay 0.
- **Single writes:** per requestor, write addr=data=random → next cycle only that requestor's Valid=1, its Out=data. 100 random iterations.
- **Dual writes:** two distinct requestors write different random values in the same cycle → next cycle both Valid=1, each Out echoes its own data, third Valid=0.
- **Triple writes:** CPU writes 0x2000←1, Acl writes 0x4000←2, DMA writes 0x3000←3 simultaneously.
  - Cycle +1: CPUValid=1 with CPUOut=1, AclValid=1 with AclOut=2, DMAValid=0.
  - Cycle +2: DMAValid=1 with DMAOut=3.
- **Read-back:** after the triple write, CPU reads 0x3000 and Acl reads 0x2000 → CPUOut=3, AclOut=1 next cycle. A read of the same address written by another port in the same cycle returns the new data.
- **Pending drop:** force DMA to be buffered, then assert DMAEn with new data in the next cycle → only the buffered request is served and the new one is dropped (exactly one DMAValid).
